// File: rtl/lock_pkg.sv
// Shared keypad-interface definitions: key encodings, player state encoding
// and a helper that limits a requested digit count to one code word.
package lock_pkg;

  localparam logic [4:0] KEY_NONE = 5'd16;
  localparam logic [3:0] EN_KEY   = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } player_state_t;

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    return (len > 4'd8) ? 4'd8 : len;
  endfunction

endpackage

// File: rtl/sequence_gap_timer.sv
// Loadable down-counter that paces the idle cycles between digit strobes.
// Stops at zero and reports it through the zero flag.
module sequence_gap_timer
  import lock_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sequence_player.sv
// Replays a latched code word as keypad strobes, most significant digit first.
// Optional leading-zero suppression is built when SEQUENCE_PLAYER_ZERO_SKIP_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, outputs idle
// EMIT  | one-cycle strobe of the current digit
// GAP   | GAP_CYCLES idle cycles before the next strobe
// DONE  | one-cycle done pulse, may accept a new start
module sequence_player
  import lock_pkg::*;
#(
  parameter int GAP_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] code,
  input  logic [3:0]  len,
  output logic [3:0]  out_en,
  output logic [4:0]  out_key,
  output logic        busy,
  output logic        done
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  player_state_t state, state_nx;
  logic [31:0]   word, word_nx, aligned, start_word;
  logic [3:0]    cnt, cnt_nx, len_c, len_m1, start_cnt;
  logic          tmr_load, tmr_zero;

  assign len_c  = clamp_len(len);
  assign len_m1 = len_c - 4'd1;
  // Push the top digit of the requested length into bits [31:28].
  assign aligned = code << {4'd8 - len_c, 2'b00};

`ifdef SEQUENCE_PLAYER_ZERO_SKIP_EN
  logic [3:0] lead_zeros;
  logic       scan_stop;

  // The last digit is never skipped, so an all-zero code still emits one 0.
  always_comb begin
    lead_zeros = 4'd0;
    scan_stop  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!scan_stop && (4'(i) < len_m1)) begin
        if (aligned[31-4*i -: 4] == 4'd0) lead_zeros = lead_zeros + 4'd1;
        else                              scan_stop  = 1'b1;
      end
    end
  end

  assign start_word = aligned << {lead_zeros, 2'b00};
  assign start_cnt  = len_m1 - lead_zeros;
`else
  assign start_word = aligned;
  assign start_cnt  = len_m1;
`endif

  always_comb begin
    state_nx = state;
    word_nx  = word;
    cnt_nx   = cnt;
    tmr_load = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (start) begin
          word_nx  = start_word;
          cnt_nx   = start_cnt;
          state_nx = (len_c == 4'd0) ? DONE : EMIT;
        end
      end
      EMIT: begin
        if (cnt == 4'd0) begin
          state_nx = DONE;
        end else begin
          word_nx = word << 4;
          cnt_nx  = cnt - 4'd1;
          if (GAP_CYCLES > 0) begin
            state_nx = GAP;
            tmr_load = 1'b1;
          end else begin
            state_nx = EMIT;
          end
        end
      end
      GAP: begin
        if (tmr_zero) state_nx = EMIT;
      end
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx = IDLE;
      tmr_load = 1'b0;
    end
  end

  sequence_gap_timer #(.W(GW)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (GAP_LOAD),
    .dec      (state == GAP),
    .zero     (tmr_zero)
  );

  // Outputs are registered from the next-state values so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      word    <= '0;
      cnt     <= '0;
      out_en  <= 4'd0;
      out_key <= KEY_NONE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      word    <= word_nx;
      cnt     <= cnt_nx;
      out_en  <= (state_nx == EMIT) ? EN_KEY : 4'd0;
      out_key <= (state_nx == EMIT) ? {1'b0, word_nx[31:28]} : KEY_NONE;
      busy    <= (state_nx == EMIT) || (state_nx == GAP);
      done    <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_sequence_player.sv
// Scoreboard bench for sequence_player: one instance with a 3-cycle gap, one back-to-back.
// Expected strobe/done events are queued at stimulus time and matched by a negedge monitor.
module tb_sequence_player;

  typedef struct {
    int         inst;
    int         kind;   // 0 strobe, 1 done
    int         cyc;
    logic [9:0] val;    // {out_en, busy, out_key}
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b, abort_a, abort_b;
  logic [31:0] code;
  logic [3:0]  len;
  logic [3:0]  en_a, en_b;
  logic [4:0]  key_a, key_b;
  logic        busy_a, busy_b, done_a, done_b;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  ev_t         q[$];
  logic [31:0] rx_a = '0;
  logic [31:0] rx_b = '0;

  sequence_player #(.GAP_CYCLES(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .code(code), .len(len),
    .out_en(en_a), .out_key(key_a), .busy(busy_a), .done(done_a)
  );

  sequence_player #(.GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .code(code), .len(len),
    .out_en(en_b), .out_key(key_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic handle(input int inst, input logic [3:0] en, input logic [4:0] key,
                        input logic b, input logic d);
    ev_t        e;
    logic [9:0] v;
    if ((en !== 4'd0) || (key !== 5'd16) || (d !== 1'b0)) begin
      v = {en, b, key};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output inst=%0d cyc=%0d actual=%h", inst, cyc, v);
      end else begin
        e = q.pop_front();
        if (e.inst != inst || e.kind != (d ? 1 : 0) || e.cyc != cyc || e.val !== v) begin
          bad++;
          $display("FAIL event inst=%0d actual(kind=%0d cyc=%0d val=%h) required(inst=%0d kind=%0d cyc=%0d val=%h)",
                   inst, d ? 1 : 0, cyc, v, e.inst, e.kind, e.cyc, e.val);
        end
      end
      if (en === 4'd10) begin
        if (inst == 0) rx_a = {rx_a[27:0], key[3:0]};
        else           rx_b = {rx_b[27:0], key[3:0]};
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      handle(0, en_a, key_a, busy_a, done_a);
      handle(1, en_b, key_b, busy_b, done_b);
    end
  end

  // Called at a negedge; returns at the following negedge with start released.
  task automatic go(input int inst, input logic [31:0] c, input logic [3:0] l,
                    input logic [31:0] digs, input int n, input bit with_done);
    ev_t e;
    int  t0, g;
    g  = (inst == 0) ? 3 : 0;
    t0 = cyc;
    code = c;
    len  = l;
    if (inst == 0) start_a = 1'b1;
    else           start_b = 1'b1;
    for (int k = 0; k < n; k++) begin
      e.inst = inst;
      e.kind = 0;
      e.cyc  = t0 + 1 + k * (g + 1);
      e.val  = {4'd10, 1'b1, 1'b0, digs[31-4*k -: 4]};
      q.push_back(e);
    end
    if (with_done) begin
      e.inst = inst;
      e.kind = 1;
      e.cyc  = (n == 0) ? t0 + 1 : t0 + 1 + (n - 1) * (g + 1) + 1;
      e.val  = {4'd0, 1'b0, 5'd16};
      q.push_back(e);
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start_a = 0; start_b = 0; abort_a = 0; abort_b = 0; code = '0; len = '0;
    repeat (2) @(negedge clk);
    chk("reset_en",   {28'd0, en_a}, 32'd0);
    chk("reset_key",  {27'd0, key_a}, 32'd16);
    chk("reset_busy", {31'd0, busy_a}, 32'd0);
    chk("reset_done", {31'd0, done_b}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic playback, gap 3
    go(0, 32'h0000_1234, 4'd4, 32'h1234_0000, 4, 1'b1);
    repeat (18) @(negedge clk);
    chk("rx_1234", {16'd0, rx_a[15:0]}, 32'h0000_1234);

    // back-to-back strobes
    go(1, 32'hDEAD_BEEF, 4'd8, 32'hDEAD_BEEF, 8, 1'b1);
    repeat (12) @(negedge clk);
    chk("rx_deadbeef", rx_b, 32'hDEAD_BEEF);

    // zero length: done only, busy stays low
    go(0, 32'h0000_1234, 4'd0, 32'h0, 0, 1'b1);
    repeat (4) @(negedge clk);

    // start during playback is ignored
    go(0, 32'h0000_5678, 4'd4, 32'h5678_0000, 4, 1'b1);
    repeat (3) @(negedge clk);
    code = 32'hFFFF_FFFF; len = 4'd8; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (16) @(negedge clk);

    // len above 8 clamps to 8
    go(1, 32'h9ABC_DEF1, 4'd15, 32'h9ABC_DEF1, 8, 1'b1);
    repeat (12) @(negedge clk);

    // restart accepted in the DONE cycle
    go(1, 32'h0000_00AB, 4'd2, 32'hAB00_0000, 2, 1'b1);
    repeat (2) @(negedge clk);
    go(1, 32'h0000_000C, 4'd1, 32'hC000_0000, 1, 1'b1);
    repeat (6) @(negedge clk);

    // abort after the second strobe
    go(0, 32'h0000_1234, 4'd4, 32'h1234_0000, 2, 1'b0);
    repeat (4) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_en",   {28'd0, en_a}, 32'd0);
    repeat (20) @(negedge clk);

    // start and abort together from idle
    code = 32'h0000_0001; len = 4'd1; start_b = 1'b1; abort_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0; abort_b = 1'b0;
    chk("start_abort_busy", {31'd0, busy_b}, 32'd0);
    repeat (10) @(negedge clk);

    // leading zeros
`ifdef SEQUENCE_PLAYER_ZERO_SKIP_EN
    go(0, 32'h0000_0070, 4'd4, 32'h7000_0000, 2, 1'b1);
    repeat (12) @(negedge clk);
    go(0, 32'h0000_0000, 4'd3, 32'h0000_0000, 1, 1'b1);
    repeat (6) @(negedge clk);
`else
    go(0, 32'h0000_0070, 4'd4, 32'h0070_0000, 4, 1'b1);
    repeat (18) @(negedge clk);
    go(0, 32'h0000_0000, 4'd3, 32'h0000_0000, 3, 1'b1);
    repeat (14) @(negedge clk);
`endif

    // asynchronous reset mid-playback
    go(0, 32'h0000_1234, 4'd4, 32'h1234_0000, 2, 1'b0);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_en",   {28'd0, en_a}, 32'd0);
    chk("midrst_key",  {27'd0, key_a}, 32'd16);
    chk("midrst_busy", {31'd0, busy_a}, 32'd0);
    chk("midrst_done", {31'd0, done_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    chk("pending_events", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
